// File: rtl/qpi_psram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : qpi_psram_responder_if
// Description : Quad-SPI PSRAM bus (chip enable + 4-bit SIO) between the
//               PSRAM controller (master) and the responder model (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface qpi_psram_responder_if;
    logic       mem_ce;
    logic       host_oe;
    logic [3:0] host_out;
    logic       sio_oe;
    logic [3:0] sio_out;
    wire  [3:0] mem_sio;

    logic       w_bus_oe;
    logic [3:0] w_bus_val;

    // Both sides contribute through one resolved driver; the responder only
    // enables its side during the read-data phase.
    assign w_bus_oe  = sio_oe | host_oe;
    assign w_bus_val = sio_oe ? sio_out : host_out;
    assign mem_sio   = w_bus_oe ? w_bus_val : 4'bz;

    modport master (
        output mem_ce,
        output host_oe,
        output host_out,
        input  sio_oe,
        input  sio_out,
        input  mem_sio
    );

    modport slave (
        input  mem_ce,
        input  mem_sio,
        output sio_oe,
        output sio_out
    );
endinterface
`default_nettype wire

// File: rtl/qpi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module      : qpi_psram_responder
// Description : LY68L6400-style QPI PSRAM responder: SPI init commands, QPI
//               0xEB read / 0x38 write bursts over a small internal byte array.
// Revision    : 1.0 - initial release
// ============================================================================
module qpi_psram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  wire                  mem_clk,
    input  wire                  rst_n,
    qpi_psram_responder_if.slave bus,
    output logic                 qpi_mode,
    output logic                 busy,
    output logic [7:0]           last_cmd,
    output logic                 cmd_error
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_CNT_W = (WAIT_CYCLES > 7) ? $clog2(WAIT_CYCLES + 1) : 3;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SPI_LAST  = c_CNT_W'(7);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(5);

    localparam logic [7:0] c_CMD_RSTEN    = 8'h66;
    localparam logic [7:0] c_CMD_RST      = 8'h99;
    localparam logic [7:0] c_CMD_QPI      = 8'h35;
    localparam logic [7:0] c_CMD_QPI_EXIT = 8'hF5;
    localparam logic [7:0] c_CMD_READ     = 8'hEB;
    localparam logic [7:0] c_CMD_WRITE    = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPI_CMD  = 3'd1,
        S_QPI_CMD  = 3'd2,
        S_QPI_ADDR = 3'd3,
        S_WR_DATA  = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_RD_DATA  = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    state_t               r_state;
    logic [6:0]           r_shift;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_rst_en;
    logic                 r_is_write;
    logic                 r_half;
    logic [3:0]           r_wr_hi;
    logic [23:0]          r_addr;
    logic                 r_qpi_mode;
    logic [7:0]           r_last_cmd;
    logic                 r_cmd_error;
    logic                 r_oe;
    logic [3:0]           r_dout;
    logic [7:0]           r_mem [c_DEPTH];

    logic [3:0]            w_sio;
    logic [7:0]            w_spi_cmd;
    logic [7:0]            w_qpi_cmd;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [7:0]            w_rd_byte;
    logic                  w_mem_we;
    logic                  w_unused_addr_hi;

    assign w_sio            = bus.mem_sio;
    assign w_spi_cmd        = {r_shift, w_sio[0]};
    assign w_qpi_cmd        = {r_shift[3:0], w_sio};
    assign w_idx            = r_addr[ADDR_WIDTH-1:0];
    assign w_rd_byte        = r_mem[w_idx];
    assign w_mem_we         = !bus.mem_ce && (r_state == S_WR_DATA) && r_half;
    assign w_unused_addr_hi = ^r_addr[23:19];

    assign qpi_mode  = r_qpi_mode;
    assign busy      = (r_state != S_IDLE);
    assign last_cmd  = r_last_cmd;
    assign cmd_error = r_cmd_error;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_rst_en    <= 1'b0;
            r_is_write  <= 1'b0;
            r_half      <= 1'b0;
            r_wr_hi     <= '0;
            r_addr      <= '0;
            r_qpi_mode  <= 1'b0;
            r_last_cmd  <= 8'h00;
            r_cmd_error <= 1'b0;
        end else begin
            r_cmd_error <= 1'b0;
            if (bus.mem_ce) begin
                // Deselect ends any transaction; a pending write half-byte is dropped.
                r_state <= S_IDLE;
                r_half  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_cnt  <= c_CNT_W'(1);
                        r_half <= 1'b0;
                        if (r_qpi_mode) begin
                            r_shift <= {3'b000, w_sio};
                            r_state <= S_QPI_CMD;
                        end else begin
                            r_shift <= {6'b000000, w_sio[0]};
                            r_state <= S_SPI_CMD;
                        end
                    end
                    S_SPI_CMD: begin
                        if (r_cnt == c_SPI_LAST) begin
                            r_last_cmd <= w_spi_cmd;
                            r_rst_en   <= (w_spi_cmd == c_CMD_RSTEN);
                            r_state    <= S_IGNORE;
                            if (w_spi_cmd == c_CMD_RST && r_rst_en)
                                r_qpi_mode <= 1'b0;
                            else if (w_spi_cmd == c_CMD_QPI)
                                r_qpi_mode <= 1'b1;
                            else if (w_spi_cmd != c_CMD_RSTEN)
                                r_cmd_error <= 1'b1;
                        end else begin
                            r_shift <= {r_shift[5:0], w_sio[0]};
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    S_QPI_CMD: begin
                        r_last_cmd <= w_qpi_cmd;
                        r_rst_en   <= (w_qpi_cmd == c_CMD_RSTEN);
                        r_cnt      <= '0;
                        r_state    <= S_IGNORE;
                        if (w_qpi_cmd == c_CMD_READ || w_qpi_cmd == c_CMD_WRITE) begin
                            r_is_write <= (w_qpi_cmd == c_CMD_WRITE);
                            r_state    <= S_QPI_ADDR;
                        end else if (w_qpi_cmd == c_CMD_RST && r_rst_en)
                            r_qpi_mode <= 1'b0;
                        else if (w_qpi_cmd == c_CMD_QPI_EXIT)
                            r_qpi_mode <= 1'b0;
                        else if (w_qpi_cmd != c_CMD_RSTEN)
                            r_cmd_error <= 1'b1;
                    end
                    S_QPI_ADDR: begin
                        // Bit 23 of the bus address is don't-care for this device.
                        r_addr <= {1'b0, r_addr[18:0], w_sio};
                        if (r_cnt == c_ADDR_LAST) begin
                            r_cnt  <= '0;
                            r_half <= 1'b0;
                            if (r_is_write)
                                r_state <= S_WR_DATA;
                            else if (WAIT_CYCLES == 0)
                                r_state <= S_RD_DATA;
                            else
                                r_state <= S_RD_WAIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WR_DATA: begin
                        if (!r_half) begin
                            r_wr_hi <= w_sio;
                            r_half  <= 1'b1;
                        end else begin
                            r_half                   <= 1'b0;
                            r_addr[ADDR_WIDTH-1:0]   <= w_idx + 1'b1;
                        end
                    end
                    S_RD_WAIT: begin
                        if (r_cnt == c_WAIT_LAST) begin
                            r_state <= S_RD_DATA;
                            r_half  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_RD_DATA: begin
                        r_half <= ~r_half;
                        if (r_half)
                            r_addr[ADDR_WIDTH-1:0] <= w_idx + 1'b1;
                    end
                    S_IGNORE: begin
                        r_state <= S_IGNORE;
                    end
                    default: begin
                        r_state <= S_IGNORE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (w_mem_we)
            r_mem[w_idx] <= {r_wr_hi, w_sio};
    end

    // Read nibbles launch on the falling edge so they are stable for the
    // controller's rising-edge sample.
    always_ff @(negedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_oe   <= (r_state == S_RD_DATA);
            r_dout <= r_half ? w_rd_byte[3:0] : w_rd_byte[7:4];
        end
    end

    assign bus.sio_oe  = r_oe & ~bus.mem_ce;
    assign bus.sio_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_qpi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpi_psram_responder
// Description : Directed + randomized bench for the QPI PSRAM responder,
//               checked against a byte-array / mode-flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpi_psram_responder;

    localparam int c_AW    = 10;
    localparam int c_WAIT  = 6;
    localparam int c_DEPTH = 1 << c_AW;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       qpi_mode;
    logic       busy;
    logic [7:0] last_cmd;
    logic       cmd_error;

    qpi_psram_responder_if bus ();

    qpi_psram_responder #(
        .ADDR_WIDTH  (c_AW),
        .WAIT_CYCLES (c_WAIT)
    ) u_dut (
        .mem_clk   (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .qpi_mode  (qpi_mode),
        .busy      (busy),
        .last_cmd  (last_cmd),
        .cmd_error (cmd_error)
    );

    always #5 clk = ~clk;

    // Reference model: the array contents the device should hold and its mode flags.
    logic [7:0] m_mem   [c_DEPTH];
    bit         m_known [c_DEPTH];
    bit         m_qpi;
    bit         m_rst_en;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, return just after the rising edge.
    task automatic tick(input logic ce, input logic oe, input logic [3:0] d);
        @(negedge clk);
        bus.mem_ce   = ce;
        bus.host_oe  = oe;
        bus.host_out = d;
        @(posedge clk);
        #1;
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        logic exp_err;
        exp_err = 1'b0;
        if (c == 8'h66) begin
            m_rst_en = 1'b1;
        end else begin
            if (c == 8'h99 && m_rst_en) m_qpi = 1'b0;
            else if (c == 8'h35)        m_qpi = 1'b1;
            else                        exp_err = 1'b1;
            m_rst_en = 1'b0;
        end
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, {3'b000, c[i]});
        check("spi_err_pulse", 32'(cmd_error), 32'(exp_err));
        tick(1'b0, 1'b0, 4'h0);
        check("spi_err_clear", 32'(cmd_error), 32'(0));
        check("spi_last_cmd", 32'(last_cmd), 32'(c));
        check("spi_qpi_mode", 32'(qpi_mode), 32'(m_qpi));
        tick(1'b1, 1'b0, 4'h0);
        check("spi_idle", 32'(busy), 32'(0));
    endtask

    task automatic qpi_byte(input logic [7:0] c);
        tick(1'b0, 1'b1, c[7:4]);
        tick(1'b0, 1'b1, c[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) tick(1'b0, 1'b1, a[i*4 +: 4]);
    endtask

    task automatic qpi_ctrl(input logic [7:0] c);
        logic exp_err;
        bit   drove;
        exp_err = 1'b0;
        drove   = 1'b0;
        if (c == 8'h66) begin
            m_rst_en = 1'b1;
        end else begin
            if (c == 8'h99 && m_rst_en) m_qpi = 1'b0;
            else if (c == 8'hF5)        m_qpi = 1'b0;
            else                        exp_err = 1'b1;
            m_rst_en = 1'b0;
        end
        qpi_byte(c);
        check("qpi_err_pulse", 32'(cmd_error), 32'(exp_err));
        tick(1'b0, 1'b0, 4'h0);
        check("qpi_err_clear", 32'(cmd_error), 32'(0));
        check("qpi_last_cmd", 32'(last_cmd), 32'(c));
        check("qpi_mode_after", 32'(qpi_mode), 32'(m_qpi));
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 4'h0);
            if (bus.sio_oe) drove = 1'b1;
        end
        check("qpi_ctrl_bus_undriven", 32'(drove), 32'(0));
        tick(1'b1, 1'b0, 4'h0);
        check("qpi_ctrl_idle", 32'(busy), 32'(0));
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [7:0] data [$], input int n_nib);
        logic [7:0] b;
        int         idx;
        m_rst_en = 1'b0;
        qpi_byte(8'h38);
        check("wr_last_cmd", 32'(last_cmd), 32'h38);
        send_addr(a);
        for (int k = 0; k < n_nib; k++) begin
            b = data[k/2];
            tick(1'b0, 1'b1, (k % 2 == 0) ? b[7:4] : b[3:0]);
        end
        tick(1'b1, 1'b0, 4'h0);
        check("wr_idle", 32'(busy), 32'(0));
        for (int k = 0; k < n_nib / 2; k++) begin
            idx          = (int'(a) + k) & (c_DEPTH - 1);
            m_mem[idx]   = data[k];
            m_known[idx] = 1'b1;
        end
    endtask

    // rst_k >= 0 pulls reset right after the posedge carrying data nibble rst_k.
    task automatic qpi_read(input logic [23:0] a, input int nbytes, input int rst_k);
        bit         early;
        bit         did_rst;
        int         idx;
        logic [7:0] b;
        logic [3:0] exp_nib;
        early   = 1'b0;
        did_rst = 1'b0;
        m_rst_en = 1'b0;
        qpi_byte(8'hEB);
        check("rd_last_cmd", 32'(last_cmd), 32'hEB);
        send_addr(a);
        for (int w = 0; w < c_WAIT; w++) begin
            tick(1'b0, 1'b0, 4'h0);
            if (bus.sio_oe) early = 1'b1;
        end
        check("rd_bus_z_before_data", 32'(early), 32'(0));
        for (int k = 0; k < 2 * nbytes; k++) begin
            idx     = (int'(a) + k / 2) & (c_DEPTH - 1);
            b       = m_mem[idx];
            exp_nib = (k % 2 == 0) ? b[7:4] : b[3:0];
            tick(1'b0, 1'b0, 4'h0);
            if (rst_k == k) begin
                rst_n = 1'b0;
                #1;
                check("rst_bus_released", 32'(bus.sio_oe), 32'(0));
                check("rst_qpi_mode", 32'(qpi_mode), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_last_cmd", 32'(last_cmd), 32'(0));
                m_qpi    = 1'b0;
                m_rst_en = 1'b0;
                did_rst  = 1'b1;
                break;
            end
            check("rd_oe", 32'(bus.sio_oe), 32'(1));
            if (m_known[idx]) check("rd_nibble", 32'(bus.mem_sio), 32'(exp_nib));
        end
        if (did_rst) begin
            @(negedge clk);
            bus.mem_ce  = 1'b1;
            bus.host_oe = 1'b0;
            rst_n       = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            tick(1'b1, 1'b0, 4'h0);
            check("rd_release", 32'(bus.sio_oe), 32'(0));
            check("rd_idle", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  q [$];
        logic [7:0]  old21;
        logic [23:0] a;
        int          len;

        n_tests  = 0;
        n_fail   = 0;
        m_qpi    = 1'b0;
        m_rst_en = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) m_known[i] = 1'b0;
        bus.mem_ce   = 1'b1;
        bus.host_oe  = 1'b0;
        bus.host_out = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_qpi_mode", 32'(qpi_mode), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_last_cmd", 32'(last_cmd), 32'(0));
        check("reset_cmd_error", 32'(cmd_error), 32'(0));
        check("reset_bus_z", 32'(bus.sio_oe), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_busy", 32'(busy), 32'(0));

        // SPI init: RST without RSTEN is rejected, then the proper sequence.
        spi_cmd(8'h99);
        spi_cmd(8'h66);
        spi_cmd(8'h99);
        spi_cmd(8'h35);

        q = {8'hAB, 8'hCD};
        qpi_write(24'h000010, q, 4);
        qpi_read(24'h000010, 2, -1);

        q.delete();
        for (int j = 0; j < 4; j++) q.push_back(8'($urandom));
        qpi_write(24'h0003FE, q, 8);
        qpi_read(24'h0003FE, 4, -1);

        // Abort mid-byte: only the completed first byte lands.
        old21 = 8'($urandom);
        q = {8'($urandom), old21};
        qpi_write(24'h000020, q, 4);
        q = {8'h11, 8'h22};
        qpi_write(24'h000020, q, 3);
        qpi_read(24'h000020, 2, -1);

        qpi_ctrl(8'hA5);
        qpi_read(24'h000010, 2, -1);

        for (int r = 0; r < 6; r++) begin
            a   = 24'($urandom);
            len = int'($urandom_range(4, 1));
            q.delete();
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            qpi_write(a, q, 2 * len);
            qpi_read(a, len, -1);
        end
        qpi_read(24'h8003FE, 4, -1);

        // QPI-side reset rules and the F5 exit.
        qpi_ctrl(8'h99);
        qpi_ctrl(8'h66);
        qpi_ctrl(8'h99);
        spi_cmd(8'h35);
        qpi_ctrl(8'hF5);
        spi_cmd(8'h35);

        qpi_read(24'h000010, 2, 1);
        spi_cmd(8'h66);
        spi_cmd(8'h99);
        spi_cmd(8'h35);
        qpi_read(24'h000010, 2, -1);
        qpi_read(24'h000020, 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
